// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch sequencer.
//   - branch / halt opcodes
//   - FSM state encoding
//   - instruction word layout (opcode [15:12], imm [11:0])
package fetch_ctrl_pkg;

    localparam int DATA_W = 16;

    localparam logic [3:0] OPC_BRF  = 4'hC;  // pc += imm
    localparam logic [3:0] OPC_BRB  = 4'hD;  // pc -= imm
    localparam logic [3:0] OPC_HALT = 4'hF;  // stop fetching until reset

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    typedef struct packed {
        logic [3:0]  opcode;
        logic [11:0] imm;
    } insn_t;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Bundle of the fetch sequencer's external signals: pc block (pc in,
// inc/add/sub/offset out), instruction memory (mem_*) and the ir
// valid/ready handshake toward decode.
//   master : the fetch sequencer
//   slave  : its environment (pc block, memory, decode)
interface fetch_ctrl_if;
    import fetch_ctrl_pkg::*;

    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] mem_addr;
    logic              mem_req;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_data;
    logic [DATA_W-1:0] ir;
    logic              ir_valid;
    logic              ir_ready;
    logic              inc;
    logic              add;
    logic              sub;
    logic [DATA_W-1:0] offset;

    modport master (
        input  pc, mem_ack, mem_data, ir_ready,
        output mem_addr, mem_req, ir, ir_valid, inc, add, sub, offset
    );

    modport slave (
        output pc, mem_ack, mem_data, ir_ready,
        input  mem_addr, mem_req, ir, ir_valid, inc, add, sub, offset
    );

endinterface

// File: rtl/fetch_ctrl_decode.sv
// Fetch decode: combinational next-pc selection from the instruction register.
//   ir     : instruction register
//   fire   : ir is being consumed this cycle
//   inc    : step pc by one (any non-branch, non-halt opcode)
//   add    : pc += offset (forward branch)
//   sub    : pc -= offset (backward branch)
//   offset : zero-extended imm for branches, else 0
//   halt   : halt opcode consumed
module fetch_ctrl_decode
    import fetch_ctrl_pkg::*;
(
    input  logic [DATA_W-1:0] ir,
    input  logic              fire,
    output logic              inc,
    output logic              add,
    output logic              sub,
    output logic [DATA_W-1:0] offset,
    output logic              halt
);

    insn_t insn;
    assign insn = insn_t'(ir);

    // Strobes only exist in the cycle ir is consumed, so each instruction
    // produces exactly one (or none, for halt).
    always_comb begin
        inc    = 1'b0;
        add    = 1'b0;
        sub    = 1'b0;
        offset = '0;
        halt   = 1'b0;
        if (fire) begin
            case (insn.opcode)
                OPC_BRF: begin
                    add    = 1'b1;
                    offset = {4'b0000, insn.imm};
                end
                OPC_BRB: begin
                    sub    = 1'b1;
                    offset = {4'b0000, insn.imm};
                end
                OPC_HALT: halt = 1'b1;
                default:  inc  = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer. Reads memory at pc, latches the word into ir,
// hands ir to decode with valid/ready and tells the pc block how to advance.
//   clk, reset : system clock, synchronous active-high reset
//   bus        : fetch_ctrl_if master (pc block, memory, decode handshake)
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   S_FETCH | mem_req high at pc, waiting for mem_ack to load ir
//   S_EXEC  | ir_valid high, waiting for ir_ready; strobe on accept
//   S_HALT  | halt consumed, idle until reset
module fetch_ctrl
    import fetch_ctrl_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    fetch_ctrl_if.master bus
);

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] ir_q;
    logic              ir_load;
    logic              fire;
    logic              halt;

    // Gating with reset keeps the pc block from moving in a reset cycle
    // that happens to land on an accepted instruction.
    assign fire    = (state == S_EXEC) && bus.ir_ready && !reset;
    assign ir_load = (state == S_FETCH) && bus.mem_ack;

    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset)        ir_q <= '0;
        else if (ir_load) ir_q <= bus.mem_data;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH: if (bus.mem_ack) state_nxt = S_EXEC;
            S_EXEC:  if (fire)        state_nxt = halt ? S_HALT : S_FETCH;
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_FETCH;
        endcase
    end

    always_comb begin
        bus.mem_req  = 1'b0;
        bus.ir_valid = 1'b0;
        case (state)
            S_FETCH: bus.mem_req  = 1'b1;
            S_EXEC:  bus.ir_valid = 1'b1;
            default: ;
        endcase
    end

    // pc only moves on the strobe edge, so it is stable for the whole fetch.
    assign bus.mem_addr = bus.pc;
    assign bus.ir       = ir_q;

    fetch_ctrl_decode u_decode (
        .ir     (ir_q),
        .fire   (fire),
        .inc    (bus.inc),
        .add    (bus.add),
        .sub    (bus.sub),
        .offset (bus.offset),
        .halt   (halt)
    );

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;
    import fetch_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fetch_ctrl_if bus ();

    fetch_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [15:0] ir;
        logic [2:0]  strobes;   // {inc, add, sub}
        logic [15:0] offset;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] last_ir = 16'h0000;

    // pc block model
    always_ff @(posedge clk) begin
        if (reset)        bus.pc <= 16'h0000;
        else if (bus.inc) bus.pc <= bus.pc + 16'd1;
        else if (bus.add) bus.pc <= bus.pc + bus.offset;
        else if (bus.sub) bus.pc <= bus.pc - bus.offset;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic exp_t expect_for(input logic [15:0] w);
        exp_t e;
        e.ir = w;
        case (w[15:12])
            4'hC:    begin e.strobes = 3'b010; e.offset = {4'h0, w[11:0]}; end
            4'hD:    begin e.strobes = 3'b001; e.offset = {4'h0, w[11:0]}; end
            4'hF:    begin e.strobes = 3'b000; e.offset = 16'h0000; end
            default: begin e.strobes = 3'b100; e.offset = 16'h0000; end
        endcase
        return e;
    endfunction

    // Entered at a negedge with the DUT in S_FETCH at address addr.
    task automatic fetch_exec(input logic [15:0] word, input int ack_wait,
                              input int rdy_wait, input logic [15:0] addr);
        exp_t e;
        bus.ir_ready = 1'b0;
        bus.mem_ack  = 1'b0;
        #1;
        check("fetch_req",     bus.mem_req,  1);
        check("fetch_addr",    bus.mem_addr, addr);
        check("fetch_valid",   bus.ir_valid, 0);
        check("fetch_strobes", {bus.inc, bus.add, bus.sub}, 0);
        for (int i = 0; i < ack_wait; i++) begin
            @(negedge clk); #1;
            check("wait_req",     bus.mem_req,  1);
            check("wait_addr",    bus.mem_addr, addr);
            check("wait_ir",      bus.ir,       last_ir);
            check("wait_strobes", {bus.inc, bus.add, bus.sub}, 0);
        end
        bus.mem_ack  = 1'b1;
        bus.mem_data = word;
        sb_q.push_back(expect_for(word));
        @(negedge clk);
        bus.mem_ack  = 1'b0;
        bus.mem_data = 16'($urandom);
        #1;
        check("exec_valid", bus.ir_valid, 1);
        check("exec_req",   bus.mem_req,  0);
        check("exec_ir",    bus.ir,       word);
        for (int i = 0; i < rdy_wait; i++) begin
            bus.mem_ack  = 1'b1;          // must be ignored outside fetch
            bus.mem_data = ~word;
            #1;
            check("stall_strobes", {bus.inc, bus.add, bus.sub}, 0);
            check("stall_valid",   bus.ir_valid, 1);
            @(negedge clk);
            bus.mem_ack = 1'b0;
            #1;
            check("stall_ir", bus.ir, word);
        end
        bus.ir_ready = 1'b1;
        #1;
        if (sb_q.size() == 0) begin
            check("sb_empty", 1, 0);
        end else begin
            e = sb_q.pop_front();
            check("accept_ir",      bus.ir,     e.ir);
            check("accept_strobes", {bus.inc, bus.add, bus.sub}, e.strobes);
            check("accept_offset",  bus.offset, e.offset);
        end
        last_ir = word;
        @(negedge clk);
        bus.ir_ready = 1'b0;
        #1;
        check("post_strobes", {bus.inc, bus.add, bus.sub}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        bus.mem_ack  = 1'b0;
        bus.mem_data = 16'h0000;
        bus.ir_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_req",     bus.mem_req,  1);
        check("rst_addr",    bus.mem_addr, 0);
        check("rst_ir",      bus.ir,       0);
        check("rst_valid",   bus.ir_valid, 0);
        check("rst_strobes", {bus.inc, bus.add, bus.sub}, 0);
        check("rst_offset",  bus.offset,   0);

        fetch_exec(16'h0123, 0, 0, 16'd0);
        fetch_exec(16'h1000, 0, 0, 16'd1);
        fetch_exec(16'h2000, 0, 0, 16'd2);
        fetch_exec(16'h3000, 0, 0, 16'd3);
        fetch_exec(16'hC005, 0, 0, 16'd4);
        fetch_exec(16'hD003, 0, 0, 16'd9);
        fetch_exec(16'h0456, 3, 0, 16'd6);
        fetch_exec(16'h0789, 0, 2, 16'd7);
        fetch_exec(16'hC000, 1, 1, 16'd8);   // imm=0 branch: refetch same pc
        fetch_exec(16'hD000, 0, 0, 16'd8);
        fetch_exec(16'hF000, 0, 0, 16'd8);

        bus.ir_ready = 1'b1;
        bus.mem_ack  = 1'b1;
        for (int i = 0; i < 12; i++) begin
            #1;
            check("halt_valid",   bus.ir_valid, 0);
            check("halt_req",     bus.mem_req,  0);
            check("halt_strobes", {bus.inc, bus.add, bus.sub}, 0);
            check("halt_pc",      bus.pc,       16'd8);
            @(negedge clk);
        end
        bus.ir_ready = 1'b0;
        bus.mem_ack  = 1'b0;

        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("halt_exit_req", bus.mem_req, 1);
        repeat (2) @(negedge clk);
        reset        = 1'b1;
        bus.mem_ack  = 1'b1;
        bus.mem_data = 16'hABCD;
        @(negedge clk);
        reset       = 1'b0;
        bus.mem_ack = 1'b0;
        #1;
        check("rstwait_ir",    bus.ir,       0);
        check("rstwait_req",   bus.mem_req,  1);
        check("rstwait_addr",  bus.mem_addr, 0);
        check("rstwait_valid", bus.ir_valid, 0);

        bus.mem_ack  = 1'b1;
        bus.mem_data = 16'h0111;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        #1;
        check("rstexec_ir", bus.ir, 16'h0111);
        reset        = 1'b1;
        bus.ir_ready = 1'b1;
        #1;
        check("rstexec_strobes", {bus.inc, bus.add, bus.sub}, 0);
        @(negedge clk);
        reset        = 1'b0;
        bus.ir_ready = 1'b0;
        #1;
        check("rstexec_ir0",   bus.ir,       0);
        check("rstexec_req",   bus.mem_req,  1);
        check("rstexec_valid", bus.ir_valid, 0);
        check("rstexec_addr",  bus.mem_addr, 0);
        last_ir = 16'h0000;

        fetch_exec(16'h0AAA, 1, 1, 16'd0);
        #1;
        check("final_addr", bus.mem_addr, 16'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
